vga_timing_param: RTL and testbench

Parametrised VGA timing generator that produces horizontal/vertical counters, sync and blanking on the `vga_if` bus for any resolution. Sync polarity is configurable, a pixel-clock enable allows use below the fabric clock rate, and frame/line strobes are provided. It sits at the head of the video pipeline and feeds draw stages through `vga_if.out`. It supersedes the fixed 800x600 generator.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_if.sv | 17 +
 rtl/vga_axis_gen.sv | 62 ++++++
 rtl/vga_timing_param.sv | 117 +++++++++++
 tb/tb_vga_timing_param.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing pipeline: coordinate/colour
// widths, the default 800x600 timing and a struct bundling one timing mode.
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int RGB_W     = 12;
  localparam int MAX_TOTAL = 2048;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_mode_t;

  // Length of one axis (line or frame) in pixels or lines.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bus: pixel coordinates, sync, blanking and colour.
// The generator drives it through modport out; draw stages read it through in.
interface vga_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic               hsync;
  logic               hblnk;
  logic               vsync;
  logic               vblnk;
  logic [RGB_W-1:0]   rgb;

  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_axis_gen.sv
// One axis of the VGA raster (horizontal or vertical). The counter advances
// on step and wraps after ACTIVE+FP+SYNC+BP positions. sync and blnk are
// registered from the next counter value, so they always describe the
// position shown on cnt. wrap is combinational: step while on the last position.
module vga_axis_gen
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COORD_W-1:0] cnt,
  output logic               sync,
  output logic               blnk,
  output logic               wrap
);

  localparam int                 TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACTIVE_C = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_LO  = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_HI  = COORD_W'(ACTIVE + FP + SYNC);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] cnt_nxt;
  logic               sync_q;
  logic               blnk_q;

  // Sync line level for a given position.
  function automatic logic sync_level(input logic [COORD_W-1:0] c);
    return (c >= SYNC_LO && c < SYNC_HI) ? POL : ~POL;
  endfunction

  // Next position along the axis, wrapping after the back porch.
  always_comb begin
    cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter and the flags that decode it, updated together on each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~POL;
    end else if (step) begin
      cnt_q  <= cnt_nxt;
      blnk_q <= (cnt_nxt >= ACTIVE_C);
      sync_q <= sync_level(cnt_nxt);
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;
  assign blnk = blnk_q;
  assign wrap = step && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator. Produces raster counters, sync and
// blanking on the vga_if bus, with line/frame start strobes. en is a pixel
// enable; nothing advances while it is low.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_timing_param
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  vga_if.out   vga_out,
  output logic line_start,
  output logic frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam vga_mode_t MODE = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
      H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_cfg
    $error("vga_timing_param: timing parameters must be nonzero and totals <= 2048");
  end

  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               v_step;

  // The vertical axis moves one line each time the horizontal axis wraps.
  assign v_step = en && h_wrap;

  vga_axis_gen #(
    .ACTIVE (int'(MODE.h_active)),
    .FP     (int'(MODE.h_fp)),
    .SYNC   (int'(MODE.h_sync)),
    .BP     (int'(MODE.h_bp)),
    .POL    (HSYNC_POL)
  ) u_h (
    .clk  (clk),
    .rst  (rst),
    .step (en),
    .cnt  (hcnt),
    .sync (vga_out.hsync),
    .blnk (vga_out.hblnk),
    .wrap (h_wrap)
  );

  vga_axis_gen #(
    .ACTIVE (int'(MODE.v_active)),
    .FP     (int'(MODE.v_fp)),
    .SYNC   (int'(MODE.v_sync)),
    .BP     (int'(MODE.v_bp)),
    .POL    (VSYNC_POL)
  ) u_v (
    .clk  (clk),
    .rst  (rst),
    .step (v_step),
    .cnt  (vcnt),
    .sync (vga_out.vsync),
    .blnk (vga_out.vblnk),
    .wrap (v_wrap)
  );

  assign vga_out.hcount = hcnt;
  assign vga_out.vcount = vcnt;
  assign vga_out.rgb    = '0;

  // Strobes mark the cycle in which the counters first show 0; they are
  // recomputed every cycle so they can never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Directed bench for vga_timing_param: a 16x8 test mode (active-high and
// active-low hsync) and the default 800x600 mode, run side by side.
module tb_vga_timing_param;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  vga_if vif_s ();
  vga_if vif_n ();
  vga_if vif_d ();

  logic ls_s, fs_s, ls_n, fs_n, ls_d, fs_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_s, fc_n, fc_d;
`endif

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif_n),
    .line_start(ls_n), .frame_start(fs_n)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_n)
`endif
  );

  vga_timing_param dut_d (
    .clk(clk), .rst(rst), .en(en), .vga_out(vif_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  int errors = 0;
  int checks = 0;

  // reference raster positions: small mode (hc, vc) and default mode (hd, vd)
  int hc, vc, hd, vd;
  bit ls_e, fs_e, lsd_e, fsd_e;

  // One clock with the given rst/en, then advance the reference positions.
  task automatic cyc(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      hc = 0; vc = 0; hd = 0; vd = 0;
      ls_e = 0; fs_e = 0; lsd_e = 0; fsd_e = 0;
    end else if (e) begin
      hc++;
      if (hc == 16) begin hc = 0; vc++; if (vc == 8) vc = 0; end
      ls_e = (hc == 0);
      fs_e = (hc == 0) && (vc == 0);
      hd++;
      if (hd == 1056) begin hd = 0; vd++; if (vd == 628) vd = 0; end
      lsd_e = (hd == 0);
      fsd_e = (hd == 0) && (vd == 0);
    end else begin
      ls_e = 0; fs_e = 0; lsd_e = 0; fsd_e = 0;
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    checks++; if (vif_s.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount: got %0d want 0", vif_s.hcount); end
    checks++; if (vif_s.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount: got %0d want 0", vif_s.vcount); end
    checks++; if (vif_s.hblnk !== 1'b0) begin errors++; $display("FAIL reset_hblnk: got %b want 0", vif_s.hblnk); end
    checks++; if (vif_s.vblnk !== 1'b0) begin errors++; $display("FAIL reset_vblnk: got %b want 0", vif_s.vblnk); end
    checks++; if (vif_s.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b want 0", vif_s.hsync); end
    checks++; if (vif_s.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", vif_s.vsync); end
    checks++; if (vif_s.rgb !== 12'd0) begin errors++; $display("FAIL reset_rgb: got %0h want 0", vif_s.rgb); end
    checks++; if (ls_s !== 1'b0) begin errors++; $display("FAIL reset_line_start: got %b want 0", ls_s); end
    checks++; if (fs_s !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", fs_s); end
    checks++; if (vif_n.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync_lowpol: got %b want 1", vif_n.hsync); end
    checks++; if (vif_d.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync_default: got %b want 0", vif_d.hsync); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (fc_s !== 16'd0 || fc_n !== 16'd0 || fc_d !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0h/%0h/%0h want 0", fc_s, fc_n, fc_d); end
`endif
  endtask

  task automatic test_small_run();
    int last_fs = -1;
    int n_fs = 0;
    for (int i = 0; i < 260; i++) begin
      cyc(1'b0, 1'b1);
      checks++; if (vif_s.hcount !== 11'(hc)) begin errors++; $display("FAIL run_hcount: got %0d want %0d", vif_s.hcount, hc); end
      checks++; if (vif_s.vcount !== 11'(vc)) begin errors++; $display("FAIL run_vcount: got %0d want %0d", vif_s.vcount, vc); end
      checks++; if (vif_s.hblnk !== (hc >= 8)) begin errors++; $display("FAIL run_hblnk: got %b at hcount %0d", vif_s.hblnk, hc); end
      checks++; if (vif_s.hsync !== (hc >= 10 && hc <= 12)) begin errors++; $display("FAIL run_hsync: got %b at hcount %0d", vif_s.hsync, hc); end
      checks++; if (vif_s.vblnk !== (vc >= 4)) begin errors++; $display("FAIL run_vblnk: got %b at vcount %0d", vif_s.vblnk, vc); end
      checks++; if (vif_s.vsync !== (vc >= 5 && vc <= 6)) begin errors++; $display("FAIL run_vsync: got %b at vcount %0d", vif_s.vsync, vc); end
      checks++; if (vif_n.hsync !== !(hc >= 10 && hc <= 12)) begin errors++; $display("FAIL run_hsync_lowpol: got %b at hcount %0d", vif_n.hsync, hc); end
      checks++; if (ls_s !== ls_e || ls_n !== ls_e) begin errors++; $display("FAIL run_line_start: got %b/%b want %b", ls_s, ls_n, ls_e); end
      checks++; if (fs_s !== fs_e || fs_n !== fs_e) begin errors++; $display("FAIL run_frame_start: got %b/%b want %b", fs_s, fs_n, fs_e); end
      if (fs_s === 1'b1) begin
        if (last_fs >= 0) begin
          checks++; if (i - last_fs != 128) begin errors++; $display("FAIL run_frame_period: got %0d want 128", i - last_fs); end
        end
        last_fs = i;
        n_fs++;
      end
    end
    checks++; if (n_fs != 2) begin errors++; $display("FAIL run_frame_count: got %0d want 2", n_fs); end
  endtask

  task automatic test_en_toggle();
    logic [COORD_W-1:0] ph, pv;
    logic phs, phb, pvs, pvb;
    int last_fs = -1;
    int n_fs = 0;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      ph = vif_s.hcount; pv = vif_s.vcount;
      phs = vif_s.hsync; phb = vif_s.hblnk; pvs = vif_s.vsync; pvb = vif_s.vblnk;
      cyc(1'b0, (i % 2) == 0);
      if ((i % 2) != 0) begin
        checks++; if (vif_s.hcount !== ph || vif_s.vcount !== pv) begin errors++; $display("FAIL hold_counts: got %0d,%0d want %0d,%0d", vif_s.hcount, vif_s.vcount, ph, pv); end
        checks++; if ({vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk} !== {phs, phb, pvs, pvb}) begin errors++; $display("FAIL hold_flags: got %b%b%b%b want %b%b%b%b", vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk, phs, phb, pvs, pvb); end
        checks++; if (ls_s !== 1'b0 || fs_s !== 1'b0) begin errors++; $display("FAIL hold_strobes: got %b%b want 00", ls_s, fs_s); end
      end else begin
        checks++; if (vif_s.hcount !== 11'(hc) || vif_s.vcount !== 11'(vc)) begin errors++; $display("FAIL toggle_counts: got %0d,%0d want %0d,%0d", vif_s.hcount, vif_s.vcount, hc, vc); end
        checks++; if (ls_s !== ls_e || fs_s !== fs_e) begin errors++; $display("FAIL toggle_strobes: got %b%b want %b%b", ls_s, fs_s, ls_e, fs_e); end
      end
      if (fs_s === 1'b1) begin
        if (last_fs >= 0) begin
          checks++; if (i - last_fs != 256) begin errors++; $display("FAIL toggle_frame_period: got %0d want 256", i - last_fs); end
        end
        last_fs = i;
        n_fs++;
      end
    end
    checks++; if (n_fs != 2) begin errors++; $display("FAIL toggle_frame_count: got %0d want 2", n_fs); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(hc == 5 && vc == 3) && guard < 200) begin
      cyc(1'b0, 1'b1);
      guard++;
    end
    checks++; if (guard >= 200) begin errors++; $display("FAIL midreset_reach: got guard %0d want < 200", guard); end
    checks++; if (vif_s.hcount !== 11'd5 || vif_s.vcount !== 11'd3) begin errors++; $display("FAIL midreset_pos: got %0d,%0d want 5,3", vif_s.hcount, vif_s.vcount); end
    cyc(1'b1, 1'b1);
    checks++; if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0) begin errors++; $display("FAIL midreset_counts: got %0d,%0d want 0,0", vif_s.hcount, vif_s.vcount); end
    checks++; if ({vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b%b%b%b want 0000", vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk); end
    checks++; if (vif_n.hsync !== 1'b1) begin errors++; $display("FAIL midreset_hsync_lowpol: got %b want 1", vif_n.hsync); end
    checks++; if (ls_s !== 1'b0 || fs_s !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got %b%b want 00", ls_s, fs_s); end
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, 1'b1);
      checks++; if (vif_s.hcount !== 11'(i) || vif_s.vcount !== 11'd0) begin errors++; $display("FAIL restart_counts: got %0d,%0d want %0d,0", vif_s.hcount, vif_s.vcount, i); end
      checks++; if (ls_s !== 1'b0 || fs_s !== 1'b0) begin errors++; $display("FAIL restart_no_strobe: got %b%b want 00", ls_s, fs_s); end
    end
    cyc(1'b0, 1'b1);
    checks++; if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd1) begin errors++; $display("FAIL restart_wrap: got %0d,%0d want 0,1", vif_s.hcount, vif_s.vcount); end
    checks++; if (ls_s !== 1'b1 || fs_s !== 1'b0) begin errors++; $display("FAIL restart_wrap_strobe: got %b%b want 10", ls_s, fs_s); end
  endtask

  task automatic test_default();
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 1056; i++) begin
      cyc(1'b0, 1'b1);
      checks++; if (vif_d.hcount !== 11'(hd)) begin errors++; $display("FAIL dflt_hcount: got %0d want %0d", vif_d.hcount, hd); end
      checks++; if (vif_d.hsync !== (hd >= 840 && hd <= 967)) begin errors++; $display("FAIL dflt_hsync: got %b at hcount %0d", vif_d.hsync, hd); end
      checks++; if (vif_d.hblnk !== (hd >= 800)) begin errors++; $display("FAIL dflt_hblnk: got %b at hcount %0d", vif_d.hblnk, hd); end
      checks++; if (ls_d !== lsd_e) begin errors++; $display("FAIL dflt_line_start: got %b want %b", ls_d, lsd_e); end
    end
    checks++; if (vif_d.vcount !== 11'd1 || ls_d !== 1'b1) begin errors++; $display("FAIL dflt_line_wrap: got vcount %0d ls %b want 1 1", vif_d.vcount, ls_d); end
    // jump the vertical counter close to the vertical sync region
    force dut_d.u_v.cnt_q = 11'd599;
    cyc(1'b0, 1'b0);
    release dut_d.u_v.cnt_q;
    vd = 599;
    cyc(1'b0, 1'b0);
    checks++; if (vif_d.vcount !== 11'd599) begin errors++; $display("FAIL dflt_preload: got %0d want 599", vif_d.vcount); end
    for (int i = 0; i < 6 * 1056; i++) begin
      cyc(1'b0, 1'b1);
      checks++; if (vif_d.vcount !== 11'(vd)) begin errors++; $display("FAIL dflt_vcount: got %0d want %0d", vif_d.vcount, vd); end
      checks++; if (vif_d.vsync !== (vd >= 601 && vd <= 604)) begin errors++; $display("FAIL dflt_vsync: got %b at vcount %0d", vif_d.vsync, vd); end
      checks++; if (vif_d.vblnk !== (vd >= 600)) begin errors++; $display("FAIL dflt_vblnk: got %b at vcount %0d", vif_d.vblnk, vd); end
    end
    // last line of the frame, then the frame wrap
    force dut_d.u_v.cnt_q = 11'd627;
    cyc(1'b0, 1'b0);
    release dut_d.u_v.cnt_q;
    vd = 627;
    for (int i = 0; i < 1056; i++) begin
      cyc(1'b0, 1'b1);
      checks++; if (fs_d !== fsd_e) begin errors++; $display("FAIL dflt_frame_start: got %b want %b at %0d,%0d", fs_d, fsd_e, hd, vd); end
    end
    checks++; if (vif_d.hcount !== 11'd0 || vif_d.vcount !== 11'd0 || fs_d !== 1'b1) begin errors++; $display("FAIL dflt_frame_wrap: got %0d,%0d fs %b want 0,0 1", vif_d.hcount, vif_d.vcount, fs_d); end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [15:0] exp_seq [3];
    int idx = 0;
    exp_seq[0] = 16'hFFFF; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0001;
    cyc(1'b1, 1'b0);
    force dut_s.frame_cnt_q = 16'hFFFE;
    cyc(1'b0, 1'b0);
    release dut_s.frame_cnt_q;
    cyc(1'b0, 1'b0);
    checks++; if (fc_s !== 16'hFFFE) begin errors++; $display("FAIL fcnt_preload: got %0h want fffe", fc_s); end
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, 1'b1);
      if (fs_s === 1'b1 && idx < 3) begin
        checks++; if (fc_s !== exp_seq[idx]) begin errors++; $display("FAIL fcnt_seq: got %0h want %0h", fc_s, exp_seq[idx]); end
        idx++;
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL fcnt_frames: got %0d want 3", idx); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_small_run();
    test_en_toggle();
    test_reset_mid();
    test_default();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
